cfg_mem_unit: RTL
=================

Name: cfg_mem_unit

Overview:
Configuration memory endpoint that sits on the far side of the control unit's store interface. It accepts 35-bit configuration words on a write-enable level and commits them to an active register. It sources the 2-bit system key used for password comparison. It also serially reads the active configuration out to downstream logic on request.

Parameters:
DEFAULT_KEY, 2'b00, syskey value after reset.
KEY_MSB, 34, MSB of the 2-bit key field inside a config word; key = word[KEY_MSB:KEY_MSB-1].

Ports:
clk  input  1  clock, posedge
arst  input  1  asynchronous reset, active-high
write_en  input  1  write enable from control unit; level, may stay high many cycles
configin  input  35  configuration word; valid whenever write_en=1
syskey  output  2  current system key to control unit
cfg_active  output  35  committed configuration
wr_ack  output  1  one-cycle pulse per successful commit
wr_err  output  1  one-cycle pulse per rejected commit (see Optional Feature)
wr_count  output  8  successful commit count, saturates at 255
rd_req  input  1  serial readout request, sampled only in IDLE
rd_busy  output  1  high while readout in progress
rd_valid  output  1  high on each cycle rd_bit is valid
rd_bit  output  1  serial config bit, LSB first

Behaviour:
- Reset (arst=1, any time, including mid-readout or mid-commit) forces:
  - syskey=DEFAULT_KEY; cfg_active=0; shadow=0; wr_count=0.
  - wr_ack=wr_err=0; rd_busy=rd_valid=rd_bit=0.
  - pending=0; we_prev=0; state=IDLE.
- Write edge detect: a write event occurs on a posedge where write_en=1 and we_prev=0; we_prev<=write_en every cycle.
  - A held-high write_en produces exactly one event.
  - On the event edge, shadow<=configin and pending<=1.
- Commit: on the first posedge where pending=1 and state=IDLE:
  - cfg_active<=shadow; syskey<=shadow[KEY_MSB:KEY_MSB-1].
  - wr_count<=sat(wr_count+1); wr_ack=1 for that one cycle; pending<=0.
  - Latency from event edge N (IDLE, no readout): cfg_active/syskey/wr_ack updated at edge N+1.
- Second write event while pending=1: shadow overwritten (last wins); only one commit, one wr_ack, count +1.
- Write event and commit on the same edge: the commit uses the old shadow; the new shadow stays pending and commits on the next edge.
- State machine: IDLE, SHIFT.
  - IDLE -> SHIFT when rd_req=1 and pending=0 (commit has priority over readout start).
  - Entering SHIFT: snap<=cfg_active; bitcnt<=0.
  - SHIFT: rd_busy=1, rd_valid=1, rd_bit=snap[bitcnt]; bitcnt increments each cycle.
  - After bitcnt=34 the next edge returns to IDLE. This gives exactly 35 valid cycles, starting the cycle after the accepting edge.
  - rd_req during SHIFT is ignored.
  - A write event during SHIFT is captured into shadow but commits only after return to IDLE. The snapshot and serial data are unaffected.
- All outputs are registered; no combinational path from inputs to outputs.
- wr_count at 255 stays 255; wr_ack still pulses.

Optional Feature:
CFG_PARITY_EN
- Defined: a commit checks even parity over all 35 shadow bits.
  - Odd parity: no update to cfg_active, syskey or wr_count; wr_err=1 for one cycle instead of wr_ack; pending cleared.
- Undefined: every commit is accepted; wr_err is tied to 0.

Test Plan:
- Reset release, no stimulus -> syskey=DEFAULT_KEY, cfg_active=0, wr_count=0, rd_busy=0 for 10 cycles.
- write_en high 5 cycles with configin=35'h6_0000_0003 (bits 34:33 = 2'b11, even parity) -> exactly one wr_ack one edge after rise; cfg_active=35'h6_0000_0003; syskey=2'b11; wr_count=1.
- cfg_active=35'h0_0000_0005, pulse rd_req -> rd_valid high 35 consecutive cycles; rd_bit sequence 1,0,1,0...0; rd_busy falls after the 35th bit.
- Write event with configin=35'h0_0000_000F at readout bit 10 -> serial stream still the old value; cfg_active updates and wr_ack fires the edge after rd_busy falls.
- Two write events 2 cycles apart while in SHIFT (values A then B) -> single wr_ack after SHIFT; cfg_active=B; wr_count +1.
- CFG_PARITY_EN defined, configin=35'h0_0000_0001 -> wr_err pulse, no wr_ack; cfg_active and syskey unchanged. Also assert arst mid-SHIFT -> rd_valid=0 immediately and state returns to IDLE.

Source files
------------

// File: rtl/cfg_mem_unit.sv
// Configuration memory endpoint: edge-detected write capture, deferred commit, and LSB-first serial readout.
// Optional build macro CFG_PARITY_EN enables the even-parity check on commit.
module cfg_mem_unit #(
    parameter logic [1:0] DEFAULT_KEY = 2'b00,
    parameter int         KEY_MSB     = 34
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        write_en,
    input  logic [34:0] configin,
    output logic [1:0]  syskey,
    output logic [34:0] cfg_active,
    output logic        wr_ack,
    output logic        wr_err,
    output logic [7:0]  wr_count,
    input  logic        rd_req,
    output logic        rd_busy,
    output logic        rd_valid,
    output logic        rd_bit
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state;
    state_t      state_next;
    logic        we_prev;
    logic        pending;
    logic [34:0] shadow;
    logic [34:0] snap;
    logic [5:0]  bitcnt;
    logic [5:0]  bitcnt_inc;
    logic        write_event;
    logic        commit;
    logic        commit_ok;

    assign write_event = write_en & ~we_prev;
    assign commit      = pending & (state == IDLE);
    assign bitcnt_inc  = bitcnt + 6'd1;

`ifdef CFG_PARITY_EN
    assign commit_ok = ~(^shadow);
`else
    assign commit_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= state_next;
    end

    // A pending commit blocks readout start so a commit never races the snapshot.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rd_req && !pending) state_next = SHIFT;
            SHIFT:   if (bitcnt == 6'd34)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A new event keeps pending set even when an older shadow commits on this edge.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            we_prev <= 1'b0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            we_prev <= write_en;
            if (write_event) begin
                shadow  <= configin;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cfg_active <= '0;
            syskey     <= DEFAULT_KEY;
            wr_count   <= '0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            wr_ack <= commit & commit_ok;
            wr_err <= commit & ~commit_ok;
            if (commit && commit_ok) begin
                cfg_active <= shadow;
                syskey     <= shadow[KEY_MSB -: 2];
                if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
            end
        end
    end

    // rd_bit is preloaded one edge ahead so it always equals snap[bitcnt] while shifting.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            snap     <= '0;
            bitcnt   <= '0;
            rd_bit   <= 1'b0;
            rd_busy  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_busy  <= (state_next == SHIFT);
            rd_valid <= (state_next == SHIFT);
            if (state == IDLE && state_next == SHIFT) begin
                snap   <= cfg_active;
                bitcnt <= '0;
                rd_bit <= cfg_active[0];
            end else if (state == SHIFT && state_next == SHIFT) begin
                bitcnt <= bitcnt_inc;
                rd_bit <= snap[bitcnt_inc];
            end else begin
                rd_bit <= 1'b0;
            end
        end
    end

endmodule
